// File: rtl/fp16_pkg.sv
// Shared fp16 types and constants for the multiplier-sharing slice.
package fp16_pkg;

   typedef logic [15:0] fp16_t;

   localparam fp16_t       FP16_ZERO = 16'h0000;
   localparam fp16_t       FP16_ONE  = 16'h3C00;
   localparam int unsigned FP16_BIAS = 15;

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// Requester-side operand bus and response bus of the shared fp16 multiplier.
interface fp16_mul_arbiter_if #(parameter int unsigned NUM_REQ = 4);
   import fp16_pkg::*;

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic  [NUM_REQ-1:0] req_valid;
   logic  [NUM_REQ-1:0] req_ready;
   fp16_t [NUM_REQ-1:0] req_a;
   fp16_t [NUM_REQ-1:0] req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   fp16_t               rsp_z;
   logic  [ID_W-1:0]    rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_z, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_z, rsp_id
   );

endinterface

// File: rtl/fp16multiplier.sv
// Combinational fp16 multiply: implicit leading one, truncated mantissa,
// zero on zero operand or exponent underflow, no NaN/Inf handling.
module fp16multiplier
   import fp16_pkg::*;
(
   input  fp16_t a,
   input  fp16_t b,
   output fp16_t z
);

   logic [21:0] prod;
   logic        norm;
   logic [7:0]  e_raw;
   logic        prod_unused;

   assign prod        = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
   assign norm        = prod[21];
   assign e_raw       = 8'(a[14:10]) + 8'(b[14:10]) + 8'(norm);
   assign prod_unused = ^prod[9:0];

   always_comb begin
      z = FP16_ZERO;
      if ((a != FP16_ZERO) && (b != FP16_ZERO) && (e_raw > 8'(FP16_BIAS))) begin
         z = {a[15] ^ b[15], 5'(e_raw - 8'(FP16_BIAS)), norm ? prod[20:11] : prod[19:10]};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module rr_arbiter #(parameter int unsigned N = 4)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic          found;

   always_comb begin
      int unsigned j;
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[PW'(j)]) begin
            found           = 1'b1;
            grant[PW'(j)]   = 1'b1;
            ptr_nxt         = (j == N - 1) ? '0 : PW'(j + 1);
         end
      end
   end

   // Pointer moves past the winner only when its request is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one fp16 multiplier among NUM_REQ requesters through a two-stage
// (operand S1, result S2) valid/ready pipeline with id-tagged results.
module fp16_mul_arbiter
   import fp16_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 32
)
(
   input  logic               clk,
   input  logic               rst_n,
   fp16_mul_arbiter_if.slave  bus,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] grant;
   logic               s1_v, s2_v, s1_en, s2_en, accept;
   fp16_t              s1_a, s1_b, sel_a, sel_b, mul_z, s2_z;
   logic [ID_W-1:0]    s1_id, sel_id, s2_id;

   assign s2_en  = !s2_v || bus.rsp_ready;
   assign s1_en  = !s1_v || s2_en;
   assign accept = s1_en && (|grant);

   assign bus.req_ready = (s1_en && rst_n) ? grant : '0;
   assign bus.rsp_valid = s2_v;
   assign bus.rsp_z     = s2_z;
   assign bus.rsp_id    = s2_id;
   assign busy          = s1_v || s2_v;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req_valid),
      .advance (s1_en),
      .grant   (grant)
   );

   // Operand mux for the granted requester
   always_comb begin
      sel_a  = FP16_ZERO;
      sel_b  = FP16_ZERO;
      sel_id = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[ID_W'(i)]) begin
            sel_a  = bus.req_a[ID_W'(i)];
            sel_b  = bus.req_b[ID_W'(i)];
            sel_id = ID_W'(i);
         end
      end
   end

   fp16multiplier u_mul (
      .a (s1_a),
      .b (s1_b),
      .z (mul_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_a  <= FP16_ZERO;
         s1_b  <= FP16_ZERO;
         s1_id <= '0;
      end else if (s1_en) begin
         s1_v <= accept;
         if (accept) begin
            s1_a  <= sel_a;
            s1_b  <= sel_b;
            s1_id <= sel_id;
         end
      end
   end

   // Result stage only captures the multiplier while S1 holds a live operand
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v  <= 1'b0;
         s2_z  <= FP16_ZERO;
         s2_id <= '0;
      end else if (s2_en) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_z  <= mul_z;
            s2_id <= s1_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (accept && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed and random checks of fp16_mul_arbiter against a transaction-level reference.
module tb_fp16_mul_arbiter;
   import fp16_pkg::*;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned CNT_W   = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              busy;
   logic [CNT_W-1:0]  op_count;

   fp16_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [15:0] z;
      int          t;
   } ent_t;

   ent_t q[$];
   int   ptr;
   int   n_acc;
   int   vectors;
   int   miscompares;

   // Reference product from real-valued significands, truncated to 10 fraction bits
   function automatic logic [15:0] ref_mul(logic [15:0] a, logic [15:0] b);
      real p;
      int  e;
      int  m;
      if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
      p = (1.0 + a[9:0] / 1024.0) * (1.0 + b[9:0] / 1024.0);
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p >= 2.0) begin
         p = p / 2.0;
         e = e + 1;
      end
      if (e <= 0) return 16'h0000;
      m = int'($floor((p - 1.0) * 1024.0));
      return {a[15] ^ b[15], 5'(e), 10'(m)};
   endfunction

   function automatic logic [15:0] rand_op();
      if ($urandom_range(0, 7) == 0) return 16'h0000;
      return {1'($urandom), 5'($urandom_range(4, 21)), 10'($urandom)};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Compare one cycle against the reference, then advance the reference
   task automatic check_model();
      logic [NUM_REQ-1:0] exp_rdy;
      int                 g;
      bit                 can;
      bit                 exp_rv;
      can = (q.size() < 2) || bus.rsp_ready;
      g   = -1;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         int j;
         j = (ptr + k) % int'(NUM_REQ);
         if (g < 0 && bus.req_valid[j]) g = j;
      end
      exp_rdy = (can && g >= 0) ? NUM_REQ'(1 << g) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      exp_rv = (q.size() > 0) && (cyc - q[0].t >= 2);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         chk("rsp_z", 32'(bus.rsp_z), 32'(q[0].z));
         chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("op_count", op_count, 32'(n_acc));
      if (exp_rv && bus.rsp_ready) void'(q.pop_front());
      if (can && g >= 0) begin
         q.push_back('{id: g, z: ref_mul(bus.req_a[g], bus.req_b[g]), t: cyc});
         ptr   = (g + 1) % int'(NUM_REQ);
         n_acc = n_acc + 1;
      end
   endtask

   task automatic edge_go();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      edge_go();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", op_count, 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      q.delete();
      ptr   = 0;
      n_acc = 0;
      edge_go();
      rst_n = 1'b1;
   endtask

   task automatic rand_operands();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         bus.req_a[i] = rand_op();
         bus.req_b[i] = rand_op();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          seq[5];
      logic [15:0] hz;
      logic [31:0] hid;
      vectors     = 0;
      miscompares = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      edge_go();
      do_reset();

      // Single requester, two-cycle latency
      bus.req_valid = 4'b0001;
      bus.req_a[0]  = FP16_ONE;
      bus.req_b[0]  = 16'h4000;
      step();
      bus.req_valid = '0;
      step();
      @(negedge clk);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t1_rsp_z", 32'(bus.rsp_z), 32'h4000);
      chk("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_model();
      edge_go();

      // All requesters valid from pointer 0: rotation 0,1,2,3,0
      do_reset();
      seq = '{0, 1, 2, 3, 0};
      rand_operands();
      bus.req_a[1]  = 16'h4200;
      bus.req_b[1]  = 16'h4400;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k < 5) chk("t2_grant", 32'(bus.req_ready), 32'(1 << seq[k]));
         if (k >= 2) begin
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t2_rsp_id", 32'(bus.rsp_id), 32'(seq[k-2]));
         end
         if (k == 3) chk("t2_rsp_z", 32'(bus.rsp_z), 32'h4A00);
         check_model();
         edge_go();
         if (k == 4) bus.req_valid = '0;
      end

      // Backpressure: pipe fills, output holds, then drains in order
      rand_operands();
      bus.req_valid = 4'b0111;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      bus.rsp_ready = 1'b0;
      hz  = '0;
      hid = '0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (s == 0) begin
            hz  = bus.rsp_z;
            hid = 32'(bus.rsp_id);
            chk("t3_stall_valid", 32'(bus.rsp_valid), 32'd1);
         end else begin
            chk("t3_hold_z", 32'(bus.rsp_z), 32'(hz));
            chk("t3_hold_id", 32'(bus.rsp_id), hid);
            chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
         end
         check_model();
         edge_go();
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      for (int k = 0; k < 6; k++) step();
      chk("t3_drained", 32'(busy), 32'd0);

      // Zero operand gives zero product
      bus.req_valid = 4'b0100;
      bus.req_a[2]  = 16'h0000;
      bus.req_b[2]  = 16'h4400;
      step();
      bus.req_valid = '0;
      step();
      @(negedge clk);
      chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t4_rsp_z", 32'(bus.rsp_z), 32'h0000);
      chk("t4_rsp_id", 32'(bus.rsp_id), 32'd2);
      check_model();
      edge_go();

      // Reset with both stages occupied, then restart from pointer 0
      rand_operands();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("t5_busy_pre", 32'(busy), 32'd1);
      do_reset();
      bus.req_valid = 4'b1010;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t5_first_grant", 32'(bus.req_ready), 32'b0010);
      check_model();
      edge_go();
      bus.req_valid = '0;
      for (int k = 0; k < 4; k++) step();

      // Random traffic and backpressure
      for (int k = 0; k < 600; k++) begin
         bus.req_valid = NUM_REQ'($urandom);
         rand_operands();
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
